// File: rtl/frame_deframer_ms.sv
// Word-level receive deframer: hunts for the frame header, validates the length word,
// forwards payload words with sof/eof markers and checks the trailing XOR checksum.
module frame_deframer_ms #(
    parameter int unsigned W           = 32,
    parameter logic [31:0] HEADER_WORD = 32'hEB94_BDA3,
    parameter logic [31:0] IDLE_WORD   = 32'h0707_0707,
    parameter int unsigned MAX_LEN     = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_data,
    input  logic         i_valid,
    input  logic         i_bit_locked,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    output logic         o_sof,
    output logic         o_eof,
    output logic         o_frame_done,
    output logic         o_frame_ok,
    output logic [15:0]  o_frame_len,
    output logic [15:0]  o_ok_cnt,
    output logic [15:0]  o_err_cnt,
    output logic [15:0]  o_len_err_cnt,
    output logic         o_in_frame
);

    localparam logic [15:0] MAX_LEN16 = MAX_LEN[15:0];
    localparam bit CFG_OK = (W == 32) && (MAX_LEN >= 1) && (MAX_LEN <= 65535)
                            && (HEADER_WORD != IDLE_WORD);

    // Idle filler needs no special handling: in HUNT every non-header word is dropped.
    if (!CFG_OK) begin : g_bad_cfg
        $error("frame_deframer_ms: unsupported parameter set");
    end

    typedef enum logic [1:0] {HUNT, LEN, PAYLOAD, CHK} state_t;

    state_t       state;
    logic [15:0]  remain;
    logic [W-1:0] xor_acc;
    logic [15:0]  len_n;
    logic         len_legal;
    logic         last_word;

    assign len_n     = i_data[15:0];
    assign len_legal = (i_data[31:16] == ~len_n) && (len_n != 16'd0) && (len_n <= MAX_LEN16);
    assign last_word = (remain == o_frame_len - 16'd1);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= HUNT;
            remain        <= '0;
            xor_acc       <= '0;
            o_data        <= '0;
            o_valid       <= 1'b0;
            o_sof         <= 1'b0;
            o_eof         <= 1'b0;
            o_frame_done  <= 1'b0;
            o_frame_ok    <= 1'b0;
            o_frame_len   <= '0;
            o_ok_cnt      <= '0;
            o_err_cnt     <= '0;
            o_len_err_cnt <= '0;
            o_in_frame    <= 1'b0;
        end else begin
            // NOTE: strobes default low with non-blocking writes so each is a clean one-cycle pulse.
            o_valid      <= 1'b0;
            o_sof        <= 1'b0;
            o_eof        <= 1'b0;
            o_frame_done <= 1'b0;
            o_frame_ok   <= 1'b0;

            if (!i_bit_locked) begin
                // Lock loss beats any word on this edge, including a checksum word.
                if (state == PAYLOAD || state == CHK) begin
                    o_frame_done <= 1'b1;
                    o_err_cnt    <= sat_inc(o_err_cnt);
                end
                state      <= HUNT;
                o_in_frame <= 1'b0;
            end else if (i_valid) begin
                case (state)
                    HUNT: begin
                        if (i_data == HEADER_WORD) begin
                            state      <= LEN;
                            o_in_frame <= 1'b1;
                        end
                    end
                    LEN: begin
                        if (len_legal) begin
                            o_frame_len <= len_n;
                            remain      <= '0;
                            xor_acc     <= '0;
                            state       <= PAYLOAD;
                        end else begin
                            o_len_err_cnt <= sat_inc(o_len_err_cnt);
                            state         <= HUNT;
                            o_in_frame    <= 1'b0;
                        end
                    end
                    PAYLOAD: begin
                        o_data  <= i_data;
                        o_valid <= 1'b1;
                        o_sof   <= (remain == 16'd0);
                        o_eof   <= last_word;
                        xor_acc <= xor_acc ^ i_data;
                        remain  <= remain + 16'd1;
                        if (last_word) begin
                            state <= CHK;
                        end
                    end
                    CHK: begin
                        o_frame_done <= 1'b1;
                        o_frame_ok   <= (i_data == xor_acc);
                        if (i_data == xor_acc) begin
                            o_ok_cnt <= sat_inc(o_ok_cnt);
                        end else begin
                            o_err_cnt <= sat_inc(o_err_cnt);
                        end
                        state      <= HUNT;
                        o_in_frame <= 1'b0;
                    end
                    default: begin
                        state      <= HUNT;
                        o_in_frame <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frame_deframer_ms.sv
// Directed bench for frame_deframer_ms: one task per scenario, expected values computed here.
module tb_frame_deframer_ms;

    localparam logic [31:0] HDR    = 32'hEB94_BDA3;
    localparam logic [31:0] IDLE_W = 32'h0707_0707;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_data;
    logic        i_valid;
    logic        i_bit_locked;
    logic [31:0] o_data;
    logic        o_valid, o_sof, o_eof, o_frame_done, o_frame_ok, o_in_frame;
    logic [15:0] o_frame_len, o_ok_cnt, o_err_cnt, o_len_err_cnt;

    typedef struct packed {
        logic [31:0] data;
        logic        sof;
        logic        eof;
    } beat_t;

    beat_t beats[$];
    beat_t exp_beats[$];
    logic  dones[$];
    int    errors = 0;
    int    checks = 0;

    frame_deframer_ms dut (
        .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid), .i_bit_locked(i_bit_locked),
        .o_data(o_data), .o_valid(o_valid), .o_sof(o_sof), .o_eof(o_eof),
        .o_frame_done(o_frame_done), .o_frame_ok(o_frame_ok), .o_frame_len(o_frame_len),
        .o_ok_cnt(o_ok_cnt), .o_err_cnt(o_err_cnt), .o_len_err_cnt(o_len_err_cnt),
        .o_in_frame(o_in_frame)
    );

    always #5 clk = ~clk;

    // Log every payload beat and frame-done pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_valid) beats.push_back({o_data, o_sof, o_eof});
            if (o_frame_done) dones.push_back(o_frame_ok);
        end
    end

    task automatic drive(input logic [31:0] d, input logic v, input logic lk);
        @(negedge clk);
        i_data = d; i_valid = v; i_bit_locked = lk;
    endtask

    task automatic word(input logic [31:0] d);
        drive(d, 1'b1, 1'b1);
    endtask

    // Invalid cycles carry the header value to show they are ignored.
    task automatic gap_cycles(input int n);
        repeat (n) drive(HDR, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; i_data = '0; i_valid = 1'b0; i_bit_locked = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        beats.delete(); dones.delete(); exp_beats.delete();
    endtask

    function automatic logic [31:0] len_word(input int n);
        logic [15:0] n16;
        n16 = 16'(n);
        return {~n16, n16};
    endfunction

    function automatic logic [31:0] xor_of(input logic [31:0] pl[$]);
        logic [31:0] x;
        x = '0;
        foreach (pl[i]) x ^= pl[i];
        return x;
    endfunction

    task automatic send_frame(input logic [31:0] pl[$], input logic [31:0] chk);
        word(HDR);
        word(len_word(pl.size()));
        foreach (pl[i]) word(pl[i]);
        word(chk);
    endtask

    task automatic expect_frame(input logic [31:0] pl[$]);
        foreach (pl[i]) exp_beats.push_back({pl[i], i == 0, i == pl.size() - 1});
    endtask

    task automatic test_reset();
        rst = 1'b1; i_data = HDR; i_valid = 1'b1; i_bit_locked = 1'b1;
        @(negedge clk);
        checks++; if ({o_valid, o_sof, o_eof, o_frame_done, o_frame_ok, o_in_frame} !== 6'b0) begin errors++; $display("FAIL reset_flags: got %b want 000000", {o_valid, o_sof, o_eof, o_frame_done, o_frame_ok, o_in_frame}); end
        checks++; if (o_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", o_data); end
        checks++; if (o_frame_len !== 16'h0) begin errors++; $display("FAIL reset_frame_len: got %h want 0", o_frame_len); end
        checks++; if (o_ok_cnt !== 16'h0) begin errors++; $display("FAIL reset_ok_cnt: got %h want 0", o_ok_cnt); end
        checks++; if (o_err_cnt !== 16'h0) begin errors++; $display("FAIL reset_err_cnt: got %h want 0", o_err_cnt); end
        checks++; if (o_len_err_cnt !== 16'h0) begin errors++; $display("FAIL reset_len_err_cnt: got %h want 0", o_len_err_cnt); end
        rst = 1'b0; i_valid = 1'b0;
    endtask

    task automatic test_good_frame();
        logic [31:0] pl[$];
        do_reset();
        pl = '{32'h1111_1111, 32'h2222_2222, 32'h4444_4444};
        expect_frame(pl);
        repeat (3) word(IDLE_W);
        word(HDR);
        word(32'hFFFC_0003);
        checks++; if (o_in_frame !== 1'b1) begin errors++; $display("FAIL good_in_frame: got %b want 1", o_in_frame); end
        word(32'h1111_1111);
        checks++; if (o_frame_len !== 16'd3) begin errors++; $display("FAIL good_frame_len: got %0d want 3", o_frame_len); end
        word(32'h2222_2222);
        checks++; if ({o_valid, o_sof, o_eof, o_data} !== {3'b110, 32'h1111_1111}) begin errors++; $display("FAIL good_first_latency: got v%b s%b e%b %h want v1 s1 e0 11111111", o_valid, o_sof, o_eof, o_data); end
        word(32'h4444_4444);
        word(32'h7777_7777);
        gap_cycles(1);
        checks++; if ({o_frame_done, o_frame_ok} !== 2'b11) begin errors++; $display("FAIL good_done_pulse: got done%b ok%b want 11", o_frame_done, o_frame_ok); end
        checks++; if (o_ok_cnt !== 16'd1) begin errors++; $display("FAIL good_ok_cnt: got %0d want 1", o_ok_cnt); end
        gap_cycles(2);
        checks++; if ({o_frame_done, o_in_frame} !== 2'b00) begin errors++; $display("FAIL good_after: got done%b in_frame%b want 00", o_frame_done, o_in_frame); end
        checks++; if (beats.size() != exp_beats.size()) begin errors++; $display("FAIL good_beat_count: got %0d want %0d", beats.size(), exp_beats.size()); end
        for (int i = 0; i < exp_beats.size() && i < beats.size(); i++) begin
            checks++; if (beats[i] !== exp_beats[i]) begin errors++; $display("FAIL good_beat[%0d]: got %h want %h", i, beats[i], exp_beats[i]); end
        end
        checks++; if ({o_err_cnt, o_len_err_cnt} !== 32'h0) begin errors++; $display("FAIL good_err_counters: got %h/%h want 0/0", o_err_cnt, o_len_err_cnt); end
    endtask

    task automatic test_bad_checksum();
        logic [31:0] pl[$];
        do_reset();
        pl = '{32'h1111_1111, 32'h2222_2222, 32'h4444_4444};
        expect_frame(pl);
        send_frame(pl, 32'h7777_7776);
        gap_cycles(3);
        checks++; if (beats.size() != exp_beats.size()) begin errors++; $display("FAIL badchk_beat_count: got %0d want %0d", beats.size(), exp_beats.size()); end
        for (int i = 0; i < exp_beats.size() && i < beats.size(); i++) begin
            checks++; if (beats[i] !== exp_beats[i]) begin errors++; $display("FAIL badchk_beat[%0d]: got %h want %h", i, beats[i], exp_beats[i]); end
        end
        checks++; if (dones.size() != 1 || dones[0] !== 1'b0) begin errors++; $display("FAIL badchk_done: got %0d pulses want one with ok=0", dones.size()); end
        checks++; if ({o_ok_cnt, o_err_cnt} !== {16'd0, 16'd1}) begin errors++; $display("FAIL badchk_counters: got ok%0d err%0d want ok0 err1", o_ok_cnt, o_err_cnt); end
    endtask

    task automatic test_len_errors();
        logic [31:0] bad_l[3];
        logic [31:0] pl[$];
        logic [31:0] v;
        do_reset();
        bad_l = '{32'h0000_0003, 32'hFFFF_0000, 32'hFBFE_0401};
        for (int i = 0; i < 3; i++) begin
            word(HDR);
            word(bad_l[i]);
            gap_cycles(1);
            checks++; if (o_len_err_cnt !== 16'(i + 1)) begin errors++; $display("FAIL len_err_cnt[%0d]: got %0d want %0d", i, o_len_err_cnt, i + 1); end
            checks++; if (o_in_frame !== 1'b0) begin errors++; $display("FAIL len_err_hunt[%0d]: got in_frame %b want 0", i, o_in_frame); end
        end
        checks++; if (beats.size() != 0 || dones.size() != 0) begin errors++; $display("FAIL len_err_quiet: got %0d beats %0d pulses want 0 0", beats.size(), dones.size()); end
        for (int i = 0; i < 1024; i++) begin
            v = 32'(i);
            pl.push_back(32'h5A00_0000 ^ (v * 32'h0001_0001));
        end
        expect_frame(pl);
        send_frame(pl, xor_of(pl));
        gap_cycles(3);
        checks++; if (o_frame_len !== 16'd1024) begin errors++; $display("FAIL maxlen_frame_len: got %0d want 1024", o_frame_len); end
        checks++; if (beats.size() != exp_beats.size()) begin errors++; $display("FAIL maxlen_beat_count: got %0d want %0d", beats.size(), exp_beats.size()); end
        for (int i = 0; i < exp_beats.size() && i < beats.size(); i++) begin
            checks++; if (beats[i] !== exp_beats[i]) begin errors++; $display("FAIL maxlen_beat[%0d]: got %h want %h", i, beats[i], exp_beats[i]); end
        end
        checks++; if (dones.size() != 1 || dones[0] !== 1'b1) begin errors++; $display("FAIL maxlen_done: got %0d pulses want one with ok=1", dones.size()); end
        checks++; if ({o_ok_cnt, o_len_err_cnt} !== {16'd1, 16'd3}) begin errors++; $display("FAIL maxlen_counters: got ok%0d len_err%0d want ok1 len_err3", o_ok_cnt, o_len_err_cnt); end
    endtask

    task automatic test_lock_loss();
        logic [31:0] pl[$];
        do_reset();
        word(HDR);
        word(32'hFFFA_0005);
        word(32'hC0DE_0001);
        word(32'hC0DE_0002);
        drive(32'hC0DE_0003, 1'b1, 1'b0);
        drive(32'h0, 1'b0, 1'b1);
        checks++; if ({o_frame_done, o_frame_ok, o_in_frame, o_valid} !== 4'b1000) begin errors++; $display("FAIL abort_pulse: got done%b ok%b in%b v%b want 1000", o_frame_done, o_frame_ok, o_in_frame, o_valid); end
        checks++; if (o_err_cnt !== 16'd1) begin errors++; $display("FAIL abort_err_cnt: got %0d want 1", o_err_cnt); end
        gap_cycles(2);
        exp_beats.push_back({32'hC0DE_0001, 1'b1, 1'b0});
        exp_beats.push_back({32'hC0DE_0002, 1'b0, 1'b0});
        pl = '{32'h0102_0304, 32'h1020_3040, 32'hAABB_CCDD};
        expect_frame(pl);
        send_frame(pl, xor_of(pl));
        gap_cycles(3);
        checks++; if (beats.size() != exp_beats.size()) begin errors++; $display("FAIL abort_beat_count: got %0d want %0d", beats.size(), exp_beats.size()); end
        for (int i = 0; i < exp_beats.size() && i < beats.size(); i++) begin
            checks++; if (beats[i] !== exp_beats[i]) begin errors++; $display("FAIL abort_beat[%0d]: got %h want %h", i, beats[i], exp_beats[i]); end
        end
        checks++; if (dones.size() != 2 || dones[0] !== 1'b0 || dones[1] !== 1'b1) begin errors++; $display("FAIL abort_then_good: got %0d pulses want ok=0 then ok=1", dones.size()); end
        // Lock loss while in LEN is silent.
        word(HDR);
        drive(32'hFFFC_0003, 1'b1, 1'b0);
        gap_cycles(2);
        checks++; if (dones.size() != 2 || o_err_cnt !== 16'd1 || o_len_err_cnt !== 16'd0) begin errors++; $display("FAIL len_lock_loss: got %0d pulses err%0d len_err%0d want 2 1 0", dones.size(), o_err_cnt, o_len_err_cnt); end
        // Checksum word arriving with lock loss: abort wins.
        word(HDR);
        word(32'hFFFC_0003);
        foreach (pl[i]) word(pl[i]);
        drive(xor_of(pl), 1'b1, 1'b0);
        gap_cycles(1);
        checks++; if ({o_frame_done, o_frame_ok} !== 2'b10) begin errors++; $display("FAIL chk_abort_pulse: got done%b ok%b want 10", o_frame_done, o_frame_ok); end
        gap_cycles(2);
        checks++; if ({o_ok_cnt, o_err_cnt} !== {16'd1, 16'd2} || dones.size() != 3) begin errors++; $display("FAIL chk_abort_counters: got ok%0d err%0d pulses%0d want 1 2 3", o_ok_cnt, o_err_cnt, dones.size()); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] seq[$];
        int gaps[$];
        do_reset();
        seq  = '{HDR, 32'hFFFC_0003, 32'hA0A0_A0A0, HDR, 32'h0000_000F, 32'h4B34_1D0C,
                 HDR, 32'hFFFE_0001, IDLE_W, IDLE_W};
        gaps = '{1, 0, 2, 1, 0, 0, 0, 1, 2, 0};
        foreach (seq[i]) begin
            word(seq[i]);
            repeat (gaps[i]) drive(HDR, 1'b0, 1'b1);
        end
        gap_cycles(3);
        exp_beats.push_back({32'hA0A0_A0A0, 1'b1, 1'b0});
        exp_beats.push_back({HDR,           1'b0, 1'b0});
        exp_beats.push_back({32'h0000_000F, 1'b0, 1'b1});
        exp_beats.push_back({IDLE_W,        1'b1, 1'b1});
        checks++; if (beats.size() != exp_beats.size()) begin errors++; $display("FAIL b2b_beat_count: got %0d want %0d", beats.size(), exp_beats.size()); end
        for (int i = 0; i < exp_beats.size() && i < beats.size(); i++) begin
            checks++; if (beats[i] !== exp_beats[i]) begin errors++; $display("FAIL b2b_beat[%0d]: got %h want %h", i, beats[i], exp_beats[i]); end
        end
        checks++; if (dones.size() != 2 || dones[0] !== 1'b1 || dones[1] !== 1'b1) begin errors++; $display("FAIL b2b_done: got %0d pulses want two with ok=1", dones.size()); end
        checks++; if ({o_ok_cnt, o_err_cnt, o_frame_len} !== {16'd2, 16'd0, 16'd1}) begin errors++; $display("FAIL b2b_counters: got ok%0d err%0d len%0d want 2 0 1", o_ok_cnt, o_err_cnt, o_frame_len); end
    endtask

    task automatic test_reset_and_saturation();
        logic [31:0] pl[$];
        do_reset();
        pl = '{32'h1111_1111, 32'h2222_2222, 32'h4444_4444};
        send_frame(pl, 32'h7777_7777);
        word(HDR);
        word(32'hFFFC_0003);
        word(32'h1111_1111);
        word(32'h2222_2222);
        rst = 1'b1;
        #1;
        beats.delete(); dones.delete();
        checks++; if ({o_valid, o_sof, o_eof, o_frame_done, o_frame_ok, o_in_frame} !== 6'b0 || o_data !== 32'h0) begin errors++; $display("FAIL midreset_outputs: got flags %b data %h want 0", {o_valid, o_sof, o_eof, o_frame_done, o_frame_ok, o_in_frame}, o_data); end
        checks++; if ({o_ok_cnt, o_err_cnt, o_len_err_cnt, o_frame_len} !== 64'h0) begin errors++; $display("FAIL midreset_counters: got ok%0d err%0d len_err%0d len%0d want 0", o_ok_cnt, o_err_cnt, o_len_err_cnt, o_frame_len); end
        @(negedge clk);
        rst = 1'b0;
        word(32'h4444_4444);
        word(32'h7777_7777);
        gap_cycles(3);
        checks++; if (beats.size() != 0 || dones.size() != 0 || o_in_frame !== 1'b0) begin errors++; $display("FAIL midreset_hunt: got %0d beats %0d pulses in_frame %b want 0 0 0", beats.size(), dones.size(), o_in_frame); end
        @(negedge clk);
        force dut.o_ok_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.o_ok_cnt;
        send_frame(pl, 32'h7777_7777);
        gap_cycles(3);
        checks++; if (dones.size() != 1 || dones[0] !== 1'b1) begin errors++; $display("FAIL sat_done: got %0d pulses want one with ok=1", dones.size()); end
        checks++; if (o_ok_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_ok_cnt: got %h want ffff", o_ok_cnt); end
        checks++; if (o_err_cnt !== 16'h0) begin errors++; $display("FAIL sat_err_cnt: got %h want 0", o_err_cnt); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_len_errors();
        test_lock_loss();
        test_back_to_back();
        test_reset_and_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/frame_deframer_ms.md
# frame_deframer_ms

Word-level deframer that sits directly downstream of the fault-tolerant bit aligner on the optical-link receive path. It consumes aligned 32-bit words and the aligner's hard-lock flag, and hunts for the frame header. It validates a length word, forwards the payload words with start/end markers, and checks a trailing XOR checksum. Per-frame status and saturating statistics counters go to the link monitor.

## Interface
Parameters:
- `W`, 32, data word width; only 32 is supported.
- `HEADER_WORD`, 32'hEB94_BDA3, frame header; same value as the aligner's alignment word.
- `IDLE_WORD`, 32'h0707_0707, inter-frame filler word.
- `MAX_LEN`, 1024, largest legal payload length in words; must be ≤ 65535.

Ports:
- `clk`  in  1  receive word clock (15.625 MHz nominal).
- `rst`  in  1  asynchronous, active-high reset.
- `i_data`  in  32  aligned word from the aligner.
- `i_valid`  in  1  `i_data` qualifier; there is no backpressure.
- `i_bit_locked`  in  1  aligner hard-lock flag.
- `o_data`  out  32  payload word.
- `o_valid`  out  1  payload word strobe.
- `o_sof`  out  1  first payload word of a frame; qualified by `o_valid`.
- `o_eof`  out  1  last payload word of a frame; qualified by `o_valid`.
- `o_frame_done`  out  1  one-cycle pulse when a frame completes or aborts.
- `o_frame_ok`  out  1  qualified by `o_frame_done`: 1 = checksum good, 0 = bad checksum or abort.
- `o_frame_len`  out  16  payload length of the current or last frame.
- `o_ok_cnt`  out  16  count of good frames; saturates at 0xFFFF.
- `o_err_cnt`  out  16  count of checksum errors and aborts; saturates.
- `o_len_err_cnt`  out  16  count of rejected length words; saturates.
- `o_in_frame`  out  1  high while the FSM is in LEN, PAYLOAD or CHK.

## Operation
Frame format, as consecutive valid words:
- `HEADER_WORD`
- Length word L: `L[15:0]` = N, `L[31:16]` = ~N.
- N payload words.
- Checksum word: XOR of all N payload words.

Cycles with `i_valid` = 0 are ignored in every state and do not advance the FSM.

FSM states and transitions:
- HUNT: a valid word equal to `HEADER_WORD` moves to LEN. Any other valid word, including `IDLE_WORD`, is dropped.
- LEN: legal when `L[31:16]` == ~`L[15:0]` and 1 ≤ N ≤ `MAX_LEN`.
  - Legal: latch N into `o_frame_len`, clear `remain` and `xor_acc`, go to PAYLOAD.
  - Illegal: increment `o_len_err_cnt`, go to HUNT. No `o_frame_done` pulse.
- PAYLOAD: each valid word is emitted on `o_data`.
  - `o_sof` is set when `remain` = 0 (first word).
  - `o_eof` is set when `remain` = N−1 (last word). With N = 1, `o_sof` and `o_eof` are set together.
  - `xor_acc` ^= word and `remain`++ on every valid word.
  - After the last word, go to CHK.
  - Words equal to `HEADER_WORD` or `IDLE_WORD` are ordinary payload here; the FSM does not resync on them.
- CHK: the next valid word is compared with `xor_acc`.
  - Pulse `o_frame_done`, set `o_frame_ok` = (equal).
  - Increment `o_ok_cnt` if equal, otherwise `o_err_cnt`.
  - Go to HUNT.

Lock loss:
- `i_bit_locked` = 0 in any state forces HUNT on the next edge and drops the current word.
- If the FSM was in PAYLOAD or CHK, pulse `o_frame_done` with `o_frame_ok` = 0 and increment `o_err_cnt`.
- An `o_eof` that was never emitted stays unemitted; downstream treats `o_frame_done` & !`o_frame_ok` as the discard signal.
- Lock loss while in LEN is silent: no pulse, no counter change.
- In HUNT with `i_bit_locked` = 0, all input is dropped.

Widths and arithmetic:
- `remain` is 16 bits; `xor_acc` is 32 bits.
- Counters are 16 bits and hold at 0xFFFF instead of wrapping.

## Timing
- All outputs are registered.
- A payload word accepted at edge k appears on `o_data`/`o_valid` in the cycle after edge k, i.e. one cycle of latency. `o_valid` is high for exactly one cycle per accepted payload word.
- `o_frame_done` is asserted for one cycle in the cycle after the checksum word or the abort edge.
- `o_frame_len` updates in the cycle after a legal length word.
- Counters update in the same cycle as the matching `o_frame_done` pulse.
- Back-to-back frames: a header immediately after a checksum word is accepted; zero gap cycles are required.
- Simultaneous checksum word and `i_bit_locked` falling: the abort wins. The pulse carries `o_frame_ok` = 0 and `o_err_cnt` increments once.
- Reset values, all 0: every output, all counters, `o_frame_len`, and the internal registers. The FSM resets to HUNT.
- Reset asserted mid-frame drops the frame with no pulse and clears the counters.

## Test plan
1. Idle×3, header, L = 0xFFFC_0003, payload 0x11111111, 0x22222222, 0x44444444, checksum 0x77777777.
   -> three `o_valid` beats with `o_sof` on the first and `o_eof` on the third; `o_frame_done` with `o_frame_ok` = 1; `o_ok_cnt` = 1; `o_frame_len` = 3.
2. Same frame with checksum 0x77777776 -> payload still forwarded; `o_frame_ok` = 0; `o_err_cnt` = 1.
3. Length words rejected, each giving no `o_valid` and `o_len_err_cnt` +1:
   - L = 0x0000_0003 (complement mismatch).
   - L = 0xFFFF_0000 (N = 0).
   - L = ~(MAX_LEN+1)<<16 | (MAX_LEN+1) (N > `MAX_LEN`).
   - L for N = `MAX_LEN` -> accepted and frame completes OK.
4. Drop `i_bit_locked` after 2 of 5 payload words -> 2 beats with no `o_eof`; `o_frame_done` with `o_frame_ok` = 0; `o_err_cnt` +1. A following good frame is accepted normally.
5. Two back-to-back frames with random `i_valid` gaps, a payload word equal to `HEADER_WORD`, and an N = 1 frame -> correct `o_sof`/`o_eof` placement (N = 1 sets both on one beat); no resync on the embedded header; `o_ok_cnt` = 2.
6. Assert `rst` mid-payload, and also preload `o_ok_cnt` to 0xFFFF and send a good frame:
   - Reset -> all outputs 0 in the next cycle; FSM in HUNT.
   - Preloaded counter -> `o_ok_cnt` stays 0xFFFF.
